alu_station: RTL
================

# alu_station

Parametrised ALU reservation station with an integrated single-cycle integer execute stage. It sits between the decoder and the ALU result bus. It buffers up to `RS_DEPTH` dispatched integer operations and snoops two broadcast buses (ALU and load/store) to resolve operand tags. Each cycle it issues the lowest-index ready entry into a result register that holds its value until the consumer accepts it. It also clears all state on a misprediction flush.

## Interface
- `RS_DEPTH`, 8: number of entries (≥2).
- `DATA_W`, 32: operand/result width.
- `TAG_W`, 5: rename tag width.
- `OP_W`, 4: opcode width.
- `TAG_FREE`, 0: tag value meaning "operand value present".
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-high reset.
- `flush` in 1: misprediction flush, synchronous.
- `disp_valid` in 1: dispatch request.
- `disp_ready` out 1: at least one free entry.
- `disp_op` in OP_W: opcode.
- `disp_dest` in TAG_W: destination tag.
- `disp_tag1` / `disp_tag2` in TAG_W: source tags.
- `disp_data1` / `disp_data2` in DATA_W: source values, used when the tag is `TAG_FREE`.
- `free_count` out clog2(RS_DEPTH+1): number of free entries.
- `cdba_valid`, `cdba_tag`, `cdba_data` in 1/TAG_W/DATA_W: snoop port A (ALU bus).
- `cdbb_valid`, `cdbb_tag`, `cdbb_data` in 1/TAG_W/DATA_W: snoop port B (load/store bus).
- `out_valid` out 1: result available.
- `out_ready` in 1: consumer accepts the result.
- `out_tag` out TAG_W: destination tag of the result.
- `out_data` out DATA_W: result value.

## Operation
- **Opcodes.** 0 = NOP/invalid. 1 ADD, 2 SUB, 3 SLL, 4 SLT, 5 SLTU, 6 XOR, 7 SRL, 8 SRA, 9 OR, 10 AND. Any other value issues normally with result 0.
- **Entry contents.** Each entry holds valid, op, dest, tag1, data1, tag2, data2.
- **Ready condition.** An entry is ready when it is valid, tag1 == `TAG_FREE` and tag2 == `TAG_FREE`.
- **Dispatch.** When `disp_valid && disp_ready && !flush`, the operation is written into the lowest-index invalid entry. A dispatch with `disp_op` == 0 is ignored.
- **Dispatch bypass.** If a source tag is not free and matches a valid snoop port tag in the same cycle, the entry stores that port's data and a free tag.
- **Snoop.** For every valid entry, each non-free tag matching `cdba_tag` (when `cdba_valid`) or `cdbb_tag` (when `cdbb_valid`) captures the data and becomes free. If both ports match, port A wins.
- **Issue.** When `out_valid == 0 || out_ready`, the lowest-index ready entry issues:
  - Its result is computed combinationally from the registered entry.
  - `out_data`, `out_tag` = dest and `out_valid` = 1 are loaded.
  - The entry is invalidated.
- **Output hold.** Otherwise, the output register holds its contents. If no entry is ready and `out_ready` is asserted, `out_valid` falls to 0.
- **Arithmetic.**
  - ADD/SUB wrap modulo 2^DATA_W.
  - Shift amount is the low clog2(DATA_W) bits of data2.
  - SRA is arithmetic on data1.
  - SLT is signed and SLTU is unsigned; both yield a zero-extended 1/0.
- **Capacity outputs.** `disp_ready` and `free_count` derive from registered valid bits only. An entry freed by issue this cycle is not counted until the next cycle.
- **Flush.** Flush beats dispatch, snoop and issue. At the next edge all entries are invalidated, `out_valid` = 0, `out_tag`/`out_data` = 0, and a same-cycle dispatch is dropped.
- **Reset.** `rst` asynchronously clears all entries, `out_valid`, `out_tag` and `out_data` to 0. While `rst` is high, `disp_ready` = 1 and `free_count` = RS_DEPTH.

## Timing
- Dispatch with both operands free at edge N: the entry is valid after N, issues at N+1, and `out_valid` is high after N+1. Minimum latency is 2 edges.
- Wakeup by snoop at edge N issues at N+1, at the earliest.
- The result is accepted at the edge where `out_valid && out_ready`. A new result may load at that same edge, giving back-to-back throughput of one per cycle.
- Dispatch, snoop update and issue of different entries all occur at the same edge. A dispatch never targets the entry issuing that cycle.
- When full (`free_count` == 0), `disp_ready` = 0 and `disp_valid` is ignored.
- `rst` or `flush` asserted while `out_valid && !out_ready` discards the held result.

## Test plan
- **Reset.** Assert `rst` mid-run → `out_valid`/`out_tag`/`out_data` go to 0 immediately; `disp_ready` = 1; `free_count` = 8.
- **Simple ADD.** Dispatch ADD, dest 3, data1 5, data2 7, tags free, `out_ready` = 1 → `out_valid` = 1, `out_tag` = 3, `out_data` = 12 after the second edge.
- **Wakeup on port B.** Dispatch SUB, tag1 = 4, data2 = 10; one cycle later drive `cdbb` tag 4, data 3 → `out_data` = 0xFFFFFFF9 one edge after the snoop.
- **Dispatch bypass.** Dispatch SRA, tag1 = 6, data2 = 4, while `cdba` broadcasts tag 6, data 0x80000000 in the same cycle → `out_data` = 0xF8000000 two edges later.
- **Full and backpressure.** Fill 8 entries, each with an unresolved tag → `disp_ready` = 0, `free_count` = 0, and a 9th dispatch is dropped. Then resolve all entries with `out_ready` = 0 → `out_data` holds the first result. Raising `out_ready` then drains results in index order, one per cycle.
- **Flush during traffic.** Assert `flush` with 5 entries valid, a held result, and a simultaneous dispatch → next cycle `out_valid` = 0, `free_count` = 8, and no later output appears.

Source files
------------

// File: rtl/alu_station.sv
// ALU reservation station: RS_DEPTH operand buffers that snoop two result buses,
// lowest-index issue through a single-cycle integer ALU into a held result register.

module alu_station_entry #(
    parameter int DATA_W   = 32,
    parameter int TAG_W    = 5,
    parameter int OP_W     = 4,
    parameter int TAG_FREE = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   alloc,
    input  logic                   clr,
    input  logic [OP_W-1:0]        d_op,
    input  logic [TAG_W-1:0]       d_dest,
    input  logic [1:0][TAG_W-1:0]  d_tag,
    input  logic [1:0][DATA_W-1:0] d_data,
    input  logic                   cdba_valid,
    input  logic [TAG_W-1:0]       cdba_tag,
    input  logic [DATA_W-1:0]      cdba_data,
    input  logic                   cdbb_valid,
    input  logic [TAG_W-1:0]       cdbb_tag,
    input  logic [DATA_W-1:0]      cdbb_data,
    output logic                   valid,
    output logic                   ready,
    output logic [OP_W-1:0]        op,
    output logic [TAG_W-1:0]       dest,
    output logic [1:0][DATA_W-1:0] data
);
    localparam logic [TAG_W-1:0] FREE = TAG_W'(TAG_FREE);

    logic [1:0][TAG_W-1:0]  tag, tag_nxt;
    logic [1:0][DATA_W-1:0] data_nxt;

    assign ready = valid && (tag[0] == FREE) && (tag[1] == FREE);

    // Freshly dispatched operands run through the same match, which yields the dispatch bypass.
    always_comb begin
        tag_nxt  = tag;
        data_nxt = data;
        for (int k = 0; k < 2; k++) begin
            if (alloc) begin
                tag_nxt[k]  = d_tag[k];
                data_nxt[k] = d_data[k];
            end
            if ((alloc || valid) && tag_nxt[k] != FREE) begin
                if (cdba_valid && cdba_tag == tag_nxt[k]) begin
                    tag_nxt[k]  = FREE;
                    data_nxt[k] = cdba_data;
                end else if (cdbb_valid && cdbb_tag == tag_nxt[k]) begin
                    tag_nxt[k]  = FREE;
                    data_nxt[k] = cdbb_data;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            op    <= '0;
            dest  <= '0;
            tag   <= '0;
            data  <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else begin
            if (alloc) begin
                valid <= 1'b1;
                op    <= d_op;
                dest  <= d_dest;
            end else if (clr) begin
                valid <= 1'b0;
            end
            tag  <= tag_nxt;
            data <= data_nxt;
        end
    end
endmodule

module alu_station #(
    parameter int RS_DEPTH = 8,
    parameter int DATA_W   = 32,
    parameter int TAG_W    = 5,
    parameter int OP_W     = 4,
    parameter int TAG_FREE = 0
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              flush,
    input  logic                              disp_valid,
    output logic                              disp_ready,
    input  logic [OP_W-1:0]                   disp_op,
    input  logic [TAG_W-1:0]                  disp_dest,
    input  logic [TAG_W-1:0]                  disp_tag1,
    input  logic [TAG_W-1:0]                  disp_tag2,
    input  logic [DATA_W-1:0]                 disp_data1,
    input  logic [DATA_W-1:0]                 disp_data2,
    output logic [$clog2(RS_DEPTH+1)-1:0]     free_count,
    input  logic                              cdba_valid,
    input  logic [TAG_W-1:0]                  cdba_tag,
    input  logic [DATA_W-1:0]                 cdba_data,
    input  logic                              cdbb_valid,
    input  logic [TAG_W-1:0]                  cdbb_tag,
    input  logic [DATA_W-1:0]                 cdbb_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [TAG_W-1:0]                  out_tag,
    output logic [DATA_W-1:0]                 out_data
);
    localparam int IDX_W = $clog2(RS_DEPTH);
    localparam int CNT_W = $clog2(RS_DEPTH + 1);
    localparam int SH_W  = $clog2(DATA_W);

    localparam logic [OP_W-1:0] OP_ADD  = OP_W'(1);
    localparam logic [OP_W-1:0] OP_SUB  = OP_W'(2);
    localparam logic [OP_W-1:0] OP_SLL  = OP_W'(3);
    localparam logic [OP_W-1:0] OP_SLT  = OP_W'(4);
    localparam logic [OP_W-1:0] OP_SLTU = OP_W'(5);
    localparam logic [OP_W-1:0] OP_XOR  = OP_W'(6);
    localparam logic [OP_W-1:0] OP_SRL  = OP_W'(7);
    localparam logic [OP_W-1:0] OP_SRA  = OP_W'(8);
    localparam logic [OP_W-1:0] OP_OR   = OP_W'(9);
    localparam logic [OP_W-1:0] OP_AND  = OP_W'(10);

    logic [RS_DEPTH-1:0]                   ent_valid, ent_ready, alloc, clr;
    logic [RS_DEPTH-1:0][OP_W-1:0]         ent_op;
    logic [RS_DEPTH-1:0][TAG_W-1:0]        ent_dest;
    logic [RS_DEPTH-1:0][1:0][DATA_W-1:0]  ent_data;

    logic [IDX_W-1:0]  iss_idx, disp_idx;
    logic              iss_any, issue_fire, do_disp;
    logic [DATA_W-1:0] a, b, res;
    logic [SH_W-1:0]   shamt;

    // Capacity looks only at registered valids, so a same-cycle issue frees nothing yet.
    always_comb begin
        iss_any    = 1'b0;
        iss_idx    = '0;
        disp_idx   = '0;
        free_count = '0;
        for (int i = RS_DEPTH - 1; i >= 0; i--) begin
            if (ent_ready[i]) begin
                iss_any = 1'b1;
                iss_idx = IDX_W'(i);
            end
            if (!ent_valid[i]) disp_idx = IDX_W'(i);
        end
        for (int i = 0; i < RS_DEPTH; i++) free_count += CNT_W'(!ent_valid[i]);
    end

    assign disp_ready = ~&ent_valid;
    assign do_disp    = disp_valid && disp_ready && !flush && (disp_op != '0);
    assign issue_fire = iss_any && (!out_valid || out_ready);

    for (genvar i = 0; i < RS_DEPTH; i++) begin : g_ent
        assign alloc[i] = do_disp && (disp_idx == IDX_W'(i));
        assign clr[i]   = issue_fire && (iss_idx == IDX_W'(i));

        alu_station_entry #(
            .DATA_W(DATA_W), .TAG_W(TAG_W), .OP_W(OP_W), .TAG_FREE(TAG_FREE)
        ) u_ent (
            .clk       (clk),
            .rst       (rst),
            .flush     (flush),
            .alloc     (alloc[i]),
            .clr       (clr[i]),
            .d_op      (disp_op),
            .d_dest    (disp_dest),
            .d_tag     ({disp_tag2, disp_tag1}),
            .d_data    ({disp_data2, disp_data1}),
            .cdba_valid(cdba_valid),
            .cdba_tag  (cdba_tag),
            .cdba_data (cdba_data),
            .cdbb_valid(cdbb_valid),
            .cdbb_tag  (cdbb_tag),
            .cdbb_data (cdbb_data),
            .valid     (ent_valid[i]),
            .ready     (ent_ready[i]),
            .op        (ent_op[i]),
            .dest      (ent_dest[i]),
            .data      (ent_data[i])
        );
    end

    assign a     = ent_data[iss_idx][0];
    assign b     = ent_data[iss_idx][1];
    assign shamt = b[SH_W-1:0];

    always_comb begin
        res = '0;
        case (ent_op[iss_idx])
            OP_ADD:  res = a + b;
            OP_SUB:  res = a - b;
            OP_SLL:  res = a << shamt;
            OP_SLT:  res = {{(DATA_W-1){1'b0}}, $signed(a) < $signed(b)};
            OP_SLTU: res = {{(DATA_W-1){1'b0}}, a < b};
            OP_XOR:  res = a ^ b;
            OP_SRL:  res = a >> shamt;
            OP_SRA:  res = $signed(a) >>> shamt;
            OP_OR:   res = a | b;
            OP_AND:  res = a & b;
            default: res = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_tag   <= '0;
            out_data  <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            out_tag   <= '0;
            out_data  <= '0;
        end else if (issue_fire) begin
            out_valid <= 1'b1;
            out_tag   <= ent_dest[iss_idx];
            out_data  <= res;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule
